imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//   Write-side companion of the instruction ROM. Receives a framed byte stream
//   (e.g. from the UART receiver), packs bytes into 32-bit instruction words and
//   writes them into a word-addressed instruction RAM that replaces the fixed ROM.
//   Holds the pipeline CPU in reset until a complete, checksum-valid image is loaded.
// PARAMETERS
//   ROM_SIZE   32        max words in instruction RAM; frame length must be 1..ROM_SIZE
//   SYNC_BYTE  8'h55     frame start byte
//   TIMEOUT    100000    idle cycles mid-frame before abort (counter width >= clog2(TIMEOUT+1))
// PORTS
//   clk           in   1   system clock, all logic on rising edge
//   reset         in   1   synchronous, active-high reset
//   rx_valid      in   1   one-cycle strobe: rx_data holds a new byte
//   rx_data       in   8   received byte
//   wr_en         out  1   one-cycle write strobe to instruction RAM
//   wr_addr       out  32  byte address, word aligned (word_index<<2; RAM indexes addr[9:2])
//   wr_data       out  32  instruction word, first received byte = bits [31:24]
//   cpu_hold      out  1   1 = keep CPU in reset; 0 only while a valid image is loaded
//   load_done     out  1   level: last frame loaded and checksum matched
//   load_err      out  1   level: last frame aborted (bad length, checksum or timeout)
//   words_loaded  out  8   words written in current/last frame
// BEHAVIOUR
//   Reset (sync, high): state=IDLE; wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1,
//     load_done=0, load_err=0, words_loaded=0, checksum/byte/timeout counters=0.
//   Frame: SYNC_BYTE, LEN (words N), 4*N data bytes MSB-first, CSUM (XOR of data bytes).
//   States:
//     IDLE : rx byte==SYNC_BYTE -> LEN; other bytes ignored.
//     LEN  : N==0 or N>ROM_SIZE -> ERR; else latch N, clear csum/index -> DATA.
//     DATA : shift byte into word reg, csum^=byte; on 4th byte of word register
//            wr_data=word, wr_addr=index<<2, wr_en=1 for exactly the next cycle,
//            words_loaded=index+1; after word N -> CSUM.
//     CSUM : byte==csum -> DONE; else -> ERR. Flags update the cycle after the byte.
//     DONE : load_done=1, cpu_hold=0. SYNC_BYTE -> LEN (hold=1, done=0, err=0).
//     ERR  : load_err=1, cpu_hold=1. SYNC_BYTE -> LEN (err=0). Other bytes ignored.
//   Entering LEN from any state: cpu_hold=1, load_done=0, load_err=0, words_loaded=0.
//   Timeout: in LEN/DATA/CSUM count cycles with rx_valid=0; reset to 0 on every
//     accepted byte; count reaching TIMEOUT -> ERR. Not counted in IDLE/DONE/ERR.
//   In LEN/DATA/CSUM, SYNC_BYTE is data (no resync); only timeout or reset aborts.
//   At most one byte per cycle; rx_valid in consecutive cycles is legal and each
//     byte is consumed. wr_en never high two cycles in a row (>=4 bytes per word).
//   Aborted frames: words already written stay in RAM; CPU stays held.
//   Reset mid-frame: immediate return to reset values; no further wr_en.
//   wr_addr/wr_data hold their last value when wr_en=0.
// TESTING
//   1 Bytes 55 02 20 04 00 03 0C 00 00 03 28 -> wr_en @addr 0 data 20040003,
//     @addr 4 data 0C000003; next cycle after 28: load_done=1, cpu_hold=0, words_loaded=2.
//   2 Same frame with csum 29 -> both writes occur; load_err=1, load_done=0, cpu_hold=1.
//   3 LEN 00 and LEN 21 (ROM_SIZE=32 -> 0x21=33) -> ERR, no wr_en; then 55 01 00 00 00 00 00
//     -> load_done=1, one write addr 0 data 00000000.
//   4 Back-to-back rx_valid for a 32-word frame -> 32 writes addr 0..0x7C, done=1;
//     TIMEOUT=16 bench: stop after 6 data bytes -> load_err=1 after exactly 16 idle cycles.
//   5 Reset asserted after 3 words of 5-word frame -> all outputs at reset values next
//     cycle; garbage before 55 ignored; new frame loads normally.
//   6 In DONE send 55 -> cpu_hold=1, load_done=0 immediately; data byte 55 inside DATA
//     is packed as data, no resync.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction RAM loader: unpacks a framed byte stream (SYNC, LEN, data, XOR checksum)
// into 32-bit word writes and holds the CPU in reset until a valid image is in place.
module imem_loader #(
    parameter int          ROM_SIZE  = 32,
    parameter logic [7:0]  SYNC_BYTE = 8'h55,
    parameter int          TIMEOUT   = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err,
    output logic [7:0]  words_loaded
);

    localparam int            TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [7:0]    ROM_WORDS = 8'(ROM_SIZE);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    function automatic logic [7:0] csum_update(input logic [7:0] csum, input logic [7:0] b);
        return csum ^ b;
    endfunction

    state_t        state_r, state_s;
    logic [7:0]    len_r, len_s;
    logic [7:0]    index_r, index_s;
    logic [1:0]    byte_cnt_r, byte_cnt_s;
    logic [23:0]   shift_r, shift_s;
    logic [7:0]    csum_r, csum_s;
    logic [TW-1:0] tmo_r, tmo_s;
    logic          tmo_hit_s;
    logic          active_s;
    logic          wr_en_r, wr_en_s;
    logic [31:0]   wr_addr_r, wr_addr_s;
    logic [31:0]   wr_data_r, wr_data_s;
    logic          hold_r, hold_s;
    logic          done_r, done_s;
    logic          err_r, err_s;
    logic [7:0]    words_r, words_s;

    // Idle-cycle watchdog: only runs while a frame is in flight.
    always_comb begin
        active_s  = (state_r == S_LEN) || (state_r == S_DATA) || (state_r == S_CSUM);
        tmo_hit_s = active_s && !rx_valid && (tmo_r == TMO_LAST);
        if (active_s && !rx_valid && !tmo_hit_s) begin
            tmo_s = tmo_r + TW'(1);
        end else begin
            tmo_s = '0;
        end
    end

    // Next-state and next-output logic for the frame parser.
    always_comb begin
        state_s    = state_r;
        len_s      = len_r;
        index_s    = index_r;
        byte_cnt_s = byte_cnt_r;
        shift_s    = shift_r;
        csum_s     = csum_r;
        wr_en_s    = 1'b0;
        wr_addr_s  = wr_addr_r;
        wr_data_s  = wr_data_r;
        hold_s     = hold_r;
        done_s     = done_r;
        err_s      = err_r;
        words_s    = words_r;

        case (state_r)
            S_IDLE, S_DONE, S_ERR: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_s = S_LEN;
                    hold_s  = 1'b1;
                    done_s  = 1'b0;
                    err_s   = 1'b0;
                    words_s = 8'd0;
                end else begin
                    state_s = state_r;
                end
            end
            S_LEN: begin
                if (rx_valid) begin
                    if ((rx_data == 8'd0) || (rx_data > ROM_WORDS)) begin
                        state_s = S_ERR;
                        err_s   = 1'b1;
                    end else begin
                        state_s    = S_DATA;
                        len_s      = rx_data;
                        index_s    = 8'd0;
                        byte_cnt_s = 2'd0;
                        csum_s     = 8'd0;
                    end
                end else if (tmo_hit_s) begin
                    state_s = S_ERR;
                    err_s   = 1'b1;
                end else begin
                    state_s = S_LEN;
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    csum_s = csum_update(csum_r, rx_data);
                    if (byte_cnt_r == 2'd3) begin
                        // Fourth byte completes the word; first byte lands in [31:24].
                        wr_en_s    = 1'b1;
                        wr_data_s  = {shift_r, rx_data};
                        wr_addr_s  = {22'd0, index_r, 2'b00};
                        words_s    = index_r + 8'd1;
                        index_s    = index_r + 8'd1;
                        byte_cnt_s = 2'd0;
                        if ((index_r + 8'd1) == len_r) begin
                            state_s = S_CSUM;
                        end else begin
                            state_s = S_DATA;
                        end
                    end else begin
                        shift_s    = {shift_r[15:0], rx_data};
                        byte_cnt_s = byte_cnt_r + 2'd1;
                    end
                end else if (tmo_hit_s) begin
                    state_s = S_ERR;
                    err_s   = 1'b1;
                end else begin
                    state_s = S_DATA;
                end
            end
            S_CSUM: begin
                if (rx_valid) begin
                    if (rx_data == csum_r) begin
                        state_s = S_DONE;
                        done_s  = 1'b1;
                        hold_s  = 1'b0;
                    end else begin
                        state_s = S_ERR;
                        err_s   = 1'b1;
                    end
                end else if (tmo_hit_s) begin
                    state_s = S_ERR;
                    err_s   = 1'b1;
                end else begin
                    state_s = S_CSUM;
                end
            end
            default: begin
                state_s = S_IDLE;
                hold_s  = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_IDLE;
            len_r      <= 8'd0;
            index_r    <= 8'd0;
            byte_cnt_r <= 2'd0;
            shift_r    <= 24'd0;
            csum_r     <= 8'd0;
            tmo_r      <= '0;
            wr_en_r    <= 1'b0;
            wr_addr_r  <= 32'd0;
            wr_data_r  <= 32'd0;
            hold_r     <= 1'b1;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            words_r    <= 8'd0;
        end else begin
            state_r    <= state_s;
            len_r      <= len_s;
            index_r    <= index_s;
            byte_cnt_r <= byte_cnt_s;
            shift_r    <= shift_s;
            csum_r     <= csum_s;
            tmo_r      <= tmo_s;
            wr_en_r    <= wr_en_s;
            wr_addr_r  <= wr_addr_s;
            wr_data_r  <= wr_data_s;
            hold_r     <= hold_s;
            done_r     <= done_s;
            err_r      <= err_s;
            words_r    <= words_s;
        end
    end

    assign wr_en        = wr_en_r;
    assign wr_addr      = wr_addr_r;
    assign wr_data      = wr_data_r;
    assign cpu_hold     = hold_r;
    assign load_done    = done_r;
    assign load_err     = err_r;
    assign words_loaded = words_r;

endmodule
